// File: rtl/mips16_serial_pkg.sv
// Shared types for the bit-serial add/subtract sequencer.
package mips16_serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } serial_state_t;

  localparam int WIDTH_DEFAULT = 16;

endpackage

// File: rtl/adder.sv
// One-bit full adder; the only carry arithmetic in the serial datapath.
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: walks a 1-bit full adder LSB-first over
// WIDTH cycles, with valid/ready handshakes on operands and result.
module serial_add_ctrl
  import mips16_serial_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serial_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, busy_q, out_valid_q;

  logic bit_sum;
  logic bit_cout;

  adder u_adder (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (bit_sum),
    .cout (bit_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          carry_d = op_sub;
          cnt_d   = '0;
          res_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {bit_sum, res_q[WIDTH-1:1]};
        carry_d = bit_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ bit_cout;
          cout_d  = bit_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = out_valid_q && (res_q == '0);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract on WIDTH-bit values.
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] a, b, input logic sub);
    logic [WIDTH-1:0] r;
    logic             c, v;
    if (sub) begin
      r = a - b;
      c = (a >= b);
      v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else begin
      {c, r} = {1'b0, a} + {1'b0, b};
      v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return {v, c, r};
  endfunction

  // Transaction-level model: busy for WIDTH edges after accept, then hold result.
  bit               m_busy, m_valid, m_clean;
  int               m_left;
  logic [WIDTH-1:0] m_res, p_res;
  logic             m_cout, m_ovf, p_cout, p_ovf;
  logic [WIDTH+1:0] m_tmp;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_clean <= 1'b1;
      m_left  <= 0;
      m_res   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_tmp = ref_op(op_a, op_b, op_sub);
        p_res  <= m_tmp[WIDTH-1:0];
        p_cout <= m_tmp[WIDTH];
        p_ovf  <= m_tmp[WIDTH+1];
        m_busy  <= 1'b1;
        m_clean <= 1'b0;
        m_left  <= WIDTH;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_res   <= p_res;
        m_cout  <= p_cout;
        m_ovf   <= p_ovf;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("result", result, m_res);
        chk("cout", cout, m_cout);
        chk("ovf", ovf, m_ovf);
        chk("zero", zero, (m_res == '0));
      end else if (m_clean) begin
        chk("result_clr", result, 0);
        chk("cout_clr", cout, 0);
        chk("ovf_clr", ovf, 0);
        chk("zero_clr", zero, 0);
      end
    end
  end

  logic [WIDTH-1:0] r_res;
  logic             r_c, r_v, r_z;
  int               r_lat;

  // Issue one op from IDLE, wait for the result, hold it 'hold' cycles, accept.
  task automatic run_op(input logic [WIDTH-1:0] a, b, input logic sub, input int hold);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_sub = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = WIDTH'($urandom);
    op_b = WIDTH'($urandom);
    op_sub = 1'($urandom);
    r_lat = 0;
    while (!out_valid && r_lat < 100) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      r_lat++;
    end
    out_ready = 1'b0;
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout actual=no out_valid required=out_valid within %0d edges", WIDTH);
    end
    r_res = result;
    r_c = cout;
    r_v = ovf;
    r_z = zero;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      op_a = WIDTH'($urandom);
      op_b = WIDTH'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_op(input string name, input logic [WIDTH-1:0] res,
                           input logic c, v, z);
    chk({name, "_res"}, r_res, res);
    chk({name, "_cout"}, r_c, c);
    chk({name, "_ovf"}, r_v, v);
    chk({name, "_zero"}, r_z, z);
    chk({name, "_lat"}, r_lat, WIDTH);
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    op_sub = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    expect_op("add_5555", 16'h5555, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1);
    expect_op("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    expect_op("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 2);
    expect_op("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 5);
    expect_op("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Abort an operation after seven bits have been processed.
    in_valid = 1'b1;
    op_a = 16'hABCD;
    op_b = 16'h1357;
    op_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    run_op(16'h0003, 16'h0004, 1'b0, 0);
    expect_op("post_abort", 16'h0007, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op(pick(), pick(), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
